// File: rtl/range_feed_pkg.sv
// Shared types for the range-finder feeder.
//   feed_state_t : sequencer state. It names what the output registers hold right now.
//   feed_entry_t : one FIFO entry at the default sample width, {last, data}.
//                  The top module packs the same layout into a WIDTH+1 vector,
//                  so it also works for non-default widths.
package range_feed_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } feed_state_t;

    localparam int FEED_WIDTH = 8;

    typedef struct packed {
        logic                  last;
        logic [FEED_WIDTH-1:0] data;
    } feed_entry_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO that buffers {last, data} entries in front of the sequencer.
// The read and write pointers each carry an extra wrap bit, so full and empty
// both come straight from the pointer difference.
// Ports:
//   clock, reset   : clock and asynchronous active-high reset (reset empties the FIFO)
//   push, wr_data  : write request and entry; ignored while full
//   pop, rd_data   : read request and head entry; ignored while empty.
//                    rd_data is valid whenever !empty.
//   full, empty    : occupancy flags
module sample_fifo #(
    parameter int ENTRY_W = 9,
    parameter int DEPTH   = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is never read before it has been written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/range_feed_sequencer.sv
// Replays buffered sample sequences into the range finder as go/finish/data.
// Ports:
//   clock, reset                 : clock and asynchronous active-high reset
//   in_data, in_valid, in_last   : incoming sample stream, with an end-of-sequence marker
//   in_ready                     : high whenever the FIFO is not full
//   data_out, go, finish         : registered range-finder protocol
//   seq_len                      : saturating sample count of the last completed sequence
//   busy                         : high when the sequencer is not IDLE
module range_feed_sequencer
    import range_feed_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic [LEN_W-1:0] seq_len,
    output logic             busy
);

    localparam int ENTRY_W = WIDTH + 1;

    feed_state_t        state, state_n;
    logic               single, single_n;
    logic [LEN_W-1:0]   cnt, cnt_n, cnt_inc;
    logic [WIDTH-1:0]   data_q, data_n;
    logic               go_q, finish_q;
    logic [LEN_W-1:0]   seq_len_q;

    logic [ENTRY_W-1:0] rd_entry;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               rd_last;
    logic [WIDTH-1:0]   rd_data;

    assign in_ready = ~fifo_full;
    assign rd_last  = rd_entry[WIDTH];
    assign rd_data  = rd_entry[WIDTH-1:0];

    sample_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (in_valid & ~fifo_full),
        .wr_data ({in_last, in_data}),
        .pop     (fifo_pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The counter sticks at all-ones, so seq_len saturates with no extra logic.
    assign cnt_inc = (cnt == {LEN_W{1'b1}}) ? cnt : cnt + LEN_W'(1);

    always_comb begin
        state_n  = state;
        single_n = single;
        cnt_n    = cnt;
        data_n   = data_q;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_n   = rd_data;
                    cnt_n    = LEN_W'(1);
                    single_n = rd_last;
                    state_n  = START;
                end
            end
            START, RUN: begin
                if (state == START && single) begin
                    // A length-1 sequence shows its sample again, this time with finish.
                    state_n = FINISH;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_n   = rd_data;
                    cnt_n    = cnt_inc;
                    state_n  = rd_last ? FINISH : RUN;
                end else begin
                    // Underrun: hold the current sample with go high. A repeated
                    // sample cannot move min/max, so the range result is unaffected.
                    state_n = RUN;
                end
            end
            FINISH: begin
                data_n   = '0;
                single_n = 1'b0;
                state_n  = IDLE;
            end
            default: begin
                data_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            single    <= 1'b0;
            cnt       <= '0;
            data_q    <= '0;
            go_q      <= 1'b0;
            finish_q  <= 1'b0;
            seq_len_q <= '0;
        end else begin
            state    <= state_n;
            single   <= single_n;
            cnt      <= cnt_n;
            data_q   <= data_n;
            // go and finish are decoded from the next state, so they change on the same edge as data_out.
            go_q     <= (state_n == START) || (state_n == RUN);
            finish_q <= (state_n == FINISH);
            if (state_n == FINISH && state != FINISH) seq_len_q <= cnt_n;
        end
    end

    assign data_out = data_q;
    assign go       = go_q;
    assign finish   = finish_q;
    assign seq_len  = seq_len_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_range_feed_sequencer.sv
module tb_range_feed_sequencer;

    logic       clock;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] data_out;
    logic       go;
    logic       finish;
    logic [7:0] seq_len;
    logic       busy;

    range_feed_sequencer #(.WIDTH(8), .DEPTH(2), .LEN_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .data_out (data_out),
        .go       (go),
        .finish   (finish),
        .seq_len  (seq_len),
        .busy     (busy)
    );

    typedef struct {
        logic       g;
        logic       f;
        logic [7:0] d;
        logic [7:0] len;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;
    bit   bp_en  = 1'b0;
    bit   prev_fin = 1'b0;
    int   bcnt = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp_push(input logic g, input logic f, input logic [7:0] d, input logic [7:0] len);
        exp_t e;
        e.g = g; e.f = f; e.d = d; e.len = len;
        q.push_back(e);
    endtask

    // Offer one sample starting at the next falling edge and hold it until it is accepted.
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready) begin
            @(negedge clock);
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL send_timeout data=%0h", d);
                break;
            end
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        gap(1);
        while ((q.size() != 0 || busy) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%0b", q.size(), busy);
        end
        repeat (2) @(negedge clock);
    endtask

    // Scoreboard monitor: it compares every go/finish cycle against the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && mon_en) begin
                chk("go_and_finish", {31'd0, go & finish}, 32'd0);
                if (prev_fin) chk("gap_after_finish", {30'd0, go, finish}, 32'd0);
                if (go || finish) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_output actual=go%0b/fin%0b/%0h expected=none", go, finish, data_out);
                    end else begin
                        e = q.pop_front();
                        chk("go", {31'd0, go}, {31'd0, e.g});
                        chk("finish", {31'd0, finish}, {31'd0, e.f});
                        chk("data_out", {24'd0, data_out}, {24'd0, e.d});
                        chk("busy_active", {31'd0, busy}, 32'd1);
                        if (e.f) chk("seq_len", {24'd0, seq_len}, {24'd0, e.len});
                    end
                end else begin
                    chk("idle_data", {24'd0, data_out}, 32'd0);
                    chk("idle_busy", {31'd0, busy}, 32'd0);
                end
                prev_fin = finish;
            end
        end
    end

    // Occupancy model for back-pressure: every sequence in that test has one
    // sample, so each rising edge of go marks exactly one pop.
    initial begin
        bit pv, g0;
        forever begin
            @(negedge clock);
            #1;
            pv = in_valid && in_ready;
            g0 = go;
            @(posedge clock);
            #1;
            if (bp_en) begin
                if (pv) bcnt++;
                if (go && !g0) bcnt--;
                chk("in_ready_vs_count", {31'd0, in_ready}, {31'd0, bcnt != 2});
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        #3;
        chk("rst_go", {31'd0, go}, 32'd0);
        chk("rst_finish", {31'd0, finish}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_seq_len", {24'd0, seq_len}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Basic sequence
        exp_push(1, 0, 8'd5, 0);
        exp_push(1, 0, 8'd9, 0);
        exp_push(1, 0, 8'd2, 0);
        exp_push(0, 1, 8'd7, 8'd4);
        send(8'd5, 0); send(8'd9, 0); send(8'd2, 0); send(8'd7, 1);
        wait_drain();

        // Single sample
        exp_push(1, 0, 8'd42, 0);
        exp_push(0, 1, 8'd42, 8'd1);
        send(8'd42, 1);
        wait_drain();

        // Underrun: START 10, three stall repeats, 20, FINISH 30
        exp_push(1, 0, 8'd10, 0);
        repeat (3) exp_push(1, 0, 8'd10, 0);
        exp_push(1, 0, 8'd20, 0);
        exp_push(0, 1, 8'd30, 8'd3);
        send(8'd10, 0);
        gap(3);
        send(8'd20, 0); send(8'd30, 1);
        wait_drain();

        // Back-pressure with single-sample sequences 1..6
        bcnt  = 0;
        bp_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            exp_push(1, 0, 8'(i), 0);
            exp_push(0, 1, 8'(i), 8'd1);
        end
        for (int i = 1; i <= 6; i++) send(8'(i), 1);
        wait_drain();
        bp_en = 1'b0;

        // Reset in the middle of a sequence
        mon_en = 1'b0;
        send(8'd11, 0); send(8'd12, 0); send(8'd13, 0);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_go", {31'd0, go}, 32'd0);
        chk("mid_rst_finish", {31'd0, finish}, 32'd0);
        chk("mid_rst_data", {24'd0, data_out}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_seq_len", {24'd0, seq_len}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        prev_fin = 1'b0;
        mon_en = 1'b1;
        exp_push(1, 0, 8'd1, 0);
        exp_push(0, 1, 8'd4, 8'd2);
        send(8'd1, 0); send(8'd4, 1);
        wait_drain();

        // Saturation: 300 samples, seq_len sticks at 255
        for (int i = 0; i < 300; i++)
            exp_push(i != 299, i == 299, 8'(i), (i == 299) ? 8'd255 : 8'd0);
        for (int i = 0; i < 300; i++) send(8'(i), i == 299);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
